// File: rtl/tdes_pkg.sv
// Shared types and pass schedule for the triple-DES pass sequencer.
package tdes_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } tdes_state_t;

    localparam logic [1:0] KEY1 = 2'd0;
    localparam logic [1:0] KEY2 = 2'd1;
    localparam logic [1:0] KEY3 = 2'd2;

    localparam logic ED_ENC = 1'b1;
    localparam logic ED_DEC = 1'b0;

    // Returns {ed_sel, key_sel}; decrypt runs the encrypt schedule backwards.
    function automatic logic [2:0] tdes_schedule(input logic mode, input logic [1:0] pass);
        logic       ed;
        logic [1:0] key;
        case (pass)
            2'd0: begin
                ed  = mode ? ED_ENC : ED_DEC;
                key = mode ? KEY1 : KEY3;
            end
            2'd1: begin
                ed  = mode ? ED_DEC : ED_ENC;
                key = KEY2;
            end
            default: begin
                ed  = mode ? ED_ENC : ED_DEC;
                key = mode ? KEY3 : KEY1;
            end
        endcase
        return {ed, key};
    endfunction

endpackage

// File: rtl/tdes_watchdog.sv
// Saturating per-pass cycle counter; flags expiry once TIMEOUT-1 is reached.
module tdes_watchdog #(
    parameter int TIMEOUT = 64
) (
    input  logic clk,
    input  logic n_rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expired
);
    localparam int W = $clog2(TIMEOUT);
    localparam logic [W-1:0] LIMIT = W'(TIMEOUT - 1);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (!n_rst)
            r_cnt <= '0;
        else if (i_clr)
            r_cnt <= '0;
        else if (i_en && r_cnt != LIMIT)
            r_cnt <= r_cnt + W'(1);
    end

    assign o_expired = (r_cnt == LIMIT);

endmodule

// File: rtl/tdes_sequencer.sv
// Drives one DES core through three chained passes (E-D-E / D-E-D) per upstream block.
module tdes_sequencer
    import tdes_pkg::*;
#(
    parameter int TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        n_rst,
    input  logic        blk_valid,
    input  logic [63:0] blk_in,
    input  logic        blk_mode,
    output logic        blk_busy,
    output logic [63:0] blk_out,
    output logic        blk_out_valid,
    output logic        blk_err,
    output logic [63:0] des_data_in,
    output logic        des_ready,
    output logic        des_ed_sel,
    output logic [1:0]  des_key_sel,
    input  logic        des_next_data,
    input  logic [63:0] des_data_out
);
    tdes_state_t r_state;
    logic [63:0] r_work;
    logic [63:0] r_blk_out;
    logic        r_mode;
    logic [1:0]  r_pass;
    logic        r_busy;
    logic        r_out_valid;
    logic        r_err;
    logic        r_des_ready;
    logic        r_ed;
    logic [1:0]  r_key;
    logic        w_expired;

    tdes_watchdog #(.TIMEOUT(TIMEOUT)) u_wdog (
        .clk       (clk),
        .n_rst     (n_rst),
        .i_clr     (r_state == ST_LOAD),
        .i_en      (r_state == ST_RUN),
        .o_expired (w_expired)
    );

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            r_state     <= ST_IDLE;
            r_work      <= '0;
            r_blk_out   <= '0;
            r_mode      <= 1'b0;
            r_pass      <= 2'd0;
            r_busy      <= 1'b0;
            r_out_valid <= 1'b0;
            r_err       <= 1'b0;
            r_des_ready <= 1'b0;
            r_ed        <= 1'b0;
            r_key       <= 2'd0;
        end else begin
            r_out_valid <= 1'b0;
            r_err       <= 1'b0;
            case (r_state)
                ST_IDLE: if (blk_valid) begin
                    r_work          <= blk_in;
                    r_mode          <= blk_mode;
                    r_pass          <= 2'd0;
                    {r_ed, r_key}   <= tdes_schedule(blk_mode, 2'd0);
                    r_des_ready     <= 1'b0;
                    r_busy          <= 1'b1;
                    r_state         <= ST_LOAD;
                end
                ST_LOAD: begin
                    r_des_ready <= 1'b1;
                    r_state     <= ST_RUN;
                end
                ST_RUN: begin
                    // Completion takes priority over a same-cycle watchdog expiry.
                    if (r_pass == 2'd3) begin
                        r_des_ready <= 1'b0;
                        r_busy      <= 1'b0;
                        r_state     <= ST_IDLE;
                    end else if (des_next_data) begin
                        r_des_ready <= 1'b0;
                        if (r_pass == 2'd2) begin
                            r_blk_out   <= des_data_out;
                            r_out_valid <= 1'b1;
                            r_state     <= ST_DONE;
                        end else begin
                            r_work        <= des_data_out;
                            r_pass        <= r_pass + 2'd1;
                            {r_ed, r_key} <= tdes_schedule(r_mode, r_pass + 2'd1);
                            r_state       <= ST_LOAD;
                        end
                    end else if (w_expired) begin
                        r_des_ready <= 1'b0;
                        r_busy      <= 1'b0;
                        r_err       <= 1'b1;
                        r_state     <= ST_IDLE;
                    end
                end
                ST_DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign blk_busy      = r_busy;
    assign blk_out       = r_blk_out;
    assign blk_out_valid = r_out_valid;
    assign blk_err       = r_err;
    assign des_data_in   = r_work;
    assign des_ready     = r_des_ready;
    assign des_ed_sel    = r_ed;
    assign des_key_sel   = r_key;

endmodule

// File: tb/tb_tdes_sequencer.sv
// Scoreboard bench: a stand-in DES core answers the handshake, a reference 3DES model predicts results.
module tb_tdes_sequencer;
    localparam int TMO = 32;
    localparam logic [63:0] GOLD = 64'h2e0618e5790a7b59;

    logic        clk = 1'b0;
    logic        n_rst = 1'b0;
    logic        blk_valid = 1'b0;
    logic [63:0] blk_in = '0;
    logic        blk_mode = 1'b0;
    logic        blk_busy, blk_out_valid, blk_err;
    logic [63:0] blk_out, des_data_in;
    logic        des_ready, des_ed_sel;
    logic [1:0]  des_key_sel;
    logic        des_next_data = 1'b0;
    logic [63:0] des_data_out = '0;

    tdes_sequencer #(.TIMEOUT(TMO)) dut (
        .clk(clk), .n_rst(n_rst), .blk_valid(blk_valid), .blk_in(blk_in), .blk_mode(blk_mode),
        .blk_busy(blk_busy), .blk_out(blk_out), .blk_out_valid(blk_out_valid), .blk_err(blk_err),
        .des_data_in(des_data_in), .des_ready(des_ready), .des_ed_sel(des_ed_sel),
        .des_key_sel(des_key_sel), .des_next_data(des_next_data), .des_data_out(des_data_out)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int ntot = 0, npass = 0;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        ntot++;
        if (got === exp) npass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", nm, got, exp, cyc);
    endtask

    // ---------------- reference model ----------------
    function automatic logic [63:0] kval(input int k);
        case (k)
            0:       return 64'h0123456789abcdef;
            1:       return 64'h5a5a0f0fc3c39696;
            default: return 64'hdeadbeef00c0ffee;
        endcase
    endfunction

    // Invertible stand-in cipher: xor with key plus a byte rotation.
    function automatic logic [63:0] enc_f(input int k, input logic [63:0] x);
        logic [63:0] t;
        t = x ^ kval(k);
        return {t[55:0], t[63:56]};
    endfunction

    function automatic logic [63:0] dec_f(input int k, input logic [63:0] x);
        return {x[7:0], x[63:8]} ^ kval(k);
    endfunction

    typedef struct { logic ed; logic [1:0] key; logic [63:0] din; } pass_t;
    typedef struct { bit is_err; logic [63:0] data; int edge_no; } sb_t;
    pass_t pq[$];
    sb_t   sb[$];

    // Stand-in core controls
    int  lat = 16;
    bit  mute = 0;
    bit  spurious = 0;
    bit  check_passes = 1;
    int  resp_cnt = 0;
    int  n_valid = 0;

    function automatic logic [63:0] tdes_ref(input logic mode, input logic [63:0] x);
        if (mode) return enc_f(2, dec_f(1, enc_f(0, x)));
        else      return dec_f(0, enc_f(1, dec_f(2, x)));
    endfunction

    task automatic push_passes(input logic mode, input logic [63:0] x);
        logic [63:0] d1, d2;
        if (mode) begin
            d1 = enc_f(0, x); d2 = dec_f(1, d1);
            pq.push_back('{1'b1, 2'd0, x});
            pq.push_back('{1'b0, 2'd1, d1});
            pq.push_back('{1'b1, 2'd2, d2});
        end else begin
            d1 = dec_f(2, x); d2 = enc_f(1, d1);
            pq.push_back('{1'b0, 2'd2, x});
            pq.push_back('{1'b1, 2'd1, d1});
            pq.push_back('{1'b0, 2'd0, d2});
        end
    endtask

    // kind: 0 = expect result, 1 = expect abort, 2 = expect nothing
    task automatic issue(input logic mode, input logic [63:0] x, input int kind, input bit hold);
        int t0;
        @(negedge clk);
        blk_valid = 1'b1; blk_in = x; blk_mode = mode;
        t0 = cyc + 1;
        if (kind == 0) begin
            push_passes(mode, x);
            sb.push_back('{1'b0, tdes_ref(mode, x), t0 + 3 * (1 + lat)});
        end else if (kind == 1) begin
            sb.push_back('{1'b1, 64'h0, t0 + 1 + TMO});
        end
        if (!hold) begin
            @(negedge clk);
            blk_valid = 1'b0; blk_in = {$urandom, $urandom}; blk_mode = $urandom_range(0, 1);
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((sb.size() != 0 || blk_busy) && n < 400) begin
            @(negedge clk); n++;
        end
        if (n >= 400) begin
            ntot++;
            $display("FAIL wait_idle: still busy=%0b pending=%0d after %0d cycles", blk_busy, sb.size(), n);
        end
        repeat (2) @(negedge clk);
    endtask

    // ---------------- stand-in DES core ----------------
    initial begin
        int  run_cnt = 0, low_run = 0;
        bit  prev_ready = 0;
        pass_t p;
        forever begin
            @(posedge clk); #1;
            des_next_data = 1'b0;
            des_data_out  = {$urandom, $urandom};
            if (des_ready) begin
                if (!prev_ready) chk("ready_gap", 64'(low_run), 64'd1);
                low_run = 0;
                run_cnt++;
                if (!mute && run_cnt == lat) begin
                    resp_cnt++;
                    if (check_passes) begin
                        if (pq.size() == 0) begin
                            ntot++;
                            $display("FAIL pass_extra: unexpected pass key=%0d ed=%0b", des_key_sel, des_ed_sel);
                        end else begin
                            p = pq.pop_front();
                            chk("pass_ed", 64'(des_ed_sel), 64'(p.ed));
                            chk("pass_key", 64'(des_key_sel), 64'(p.key));
                            chk("pass_din", des_data_in, p.din);
                        end
                    end
                    des_next_data = 1'b1;
                    des_data_out  = des_ed_sel ? enc_f(int'(des_key_sel), des_data_in)
                                               : dec_f(int'(des_key_sel), des_data_in);
                end
            end else begin
                run_cnt = 0;
                if (blk_busy) begin
                    low_run++;
                    if (spurious) des_next_data = 1'b1;
                end else begin
                    low_run = 0;
                end
            end
            prev_ready = des_ready;
        end
    end

    // ---------------- output monitor ----------------
    initial begin
        bit  busy_pending = 0;
        sb_t e;
        forever begin
            @(posedge clk); #1;
            if (busy_pending) begin
                chk("busy_after_done", 64'(blk_busy), 64'd0);
                busy_pending = 0;
            end
            if (blk_out_valid) n_valid++;
            if (blk_out_valid || blk_err) begin
                if (sb.size() == 0) begin
                    ntot++;
                    $display("FAIL unexpected_out: valid=%0b err=%0b out=%h", blk_out_valid, blk_err, blk_out);
                end else begin
                    e = sb.pop_front();
                    chk("out_kind", {62'd0, blk_err, blk_out_valid}, e.is_err ? 64'd2 : 64'd1);
                    chk("out_cycle", 64'(cyc), 64'(e.edge_no));
                    if (e.is_err) begin
                        chk("busy_at_err", 64'(blk_busy), 64'd0);
                    end else begin
                        chk("blk_out", blk_out, e.data);
                        chk("ready_at_done", 64'(des_ready), 64'd0);
                        busy_pending = 1;
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    // ---------------- scenarios ----------------
    initial begin
        int r0, n, v0;
        logic [63:0] enc_res;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_outputs", {blk_busy, blk_out_valid, blk_err, des_ready, des_ed_sel, des_key_sel},
            64'd0);
        chk("rst_blk_out", blk_out, 64'd0);
        chk("rst_din", des_data_in, 64'd0);
        @(negedge clk); n_rst = 1'b1;
        repeat (2) @(negedge clk);

        // Encrypt, then decrypt round trip
        lat = 16;
        enc_res = tdes_ref(1'b1, GOLD);
        issue(1'b1, GOLD, 0, 0);
        wait_idle();
        issue(1'b0, enc_res, 0, 0);
        wait_idle();
        chk("roundtrip", blk_out, GOLD);

        // Handshake: blk_valid held while busy, spurious next_data in LOAD/DONE
        v0 = n_valid;
        spurious = 1;
        issue(1'b1, 64'h0f1e2d3c4b5a6978, 0, 1);
        n = 0;
        while (n < 200) begin
            @(negedge clk);
            if (blk_out_valid) break;
            blk_in = {$urandom, $urandom}; blk_mode = $urandom_range(0, 1);
            n++;
        end
        blk_valid = 1'b0;
        spurious = 0;
        repeat (10) @(negedge clk);
        wait_idle();
        chk("single_valid", 64'(n_valid - v0), 64'd1);

        // Timeout: core never answers
        mute = 1;
        issue(1'b1, {$urandom, $urandom}, 1, 0);
        wait_idle();
        mute = 0;
        // Answer on the expiry cycle: completion wins
        lat = TMO;
        issue(1'b0, {$urandom, $urandom}, 0, 0);
        wait_idle();

        // Reset in the middle of pass 2
        lat = 16;
        check_passes = 0;
        r0 = resp_cnt;
        issue(1'b1, GOLD, 2, 0);
        n = 0;
        while (resp_cnt == r0 && n < 200) begin @(negedge clk); n++; end
        if (n >= 200) begin ntot++; $display("FAIL rst_wait: core never answered pass 1"); end
        repeat (4) @(negedge clk);
        n_rst = 1'b0;
        @(posedge clk); #1;
        chk("midrst_outputs", {blk_busy, blk_out_valid, blk_err, des_ready, des_ed_sel, des_key_sel},
            64'd0);
        chk("midrst_blk_out", blk_out, 64'd0);
        chk("midrst_din", des_data_in, 64'd0);
        @(negedge clk); n_rst = 1'b1;
        check_passes = 1;
        repeat (3) @(negedge clk);
        issue(1'b1, GOLD, 0, 0);
        wait_idle();
        chk("rerun_enc", blk_out, enc_res);

        // Randomised blocks, modes and core latencies
        for (int i = 0; i < 10; i++) begin
            lat = $urandom_range(1, TMO);
            issue(1'(($urandom_range(0, 1))), {$urandom, $urandom}, 0, 0);
            wait_idle();
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        chk("sb_drained", 64'(sb.size()), 64'd0);
        chk("passes_drained", 64'(pq.size()), 64'd0);
        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule

// File: doc/tdes_sequencer.md
# tdes_sequencer

Triple-DES pass sequencer: the initiator side of the DES core's `ready`/`next_data` handshake. It accepts one 64-bit block from the upstream I2C datapath and drives a single `des2` core through three chained passes: E-D-E for encrypt, D-E-D with reversed key order for decrypt. Each pass's output is fed back as the next pass's input. The final result is returned upstream with a one-cycle valid strobe. A watchdog aborts the operation if the core stops responding.

## Interface
- `TIMEOUT`, default 64: maximum RUN cycles per pass before abort (≥2).
- `clk` in 1: system clock.
- `n_rst` in 1: reset; synchronous, active-low.
- `blk_valid` in 1: upstream block request; sampled only in IDLE.
- `blk_in` in 64: plaintext or ciphertext block.
- `blk_mode` in 1: 1 = encrypt, 0 = decrypt; sampled with `blk_valid`.
- `blk_busy` out 1: high in every non-IDLE state.
- `blk_out` out 64: 3DES result; holds its value until the next completion.
- `blk_out_valid` out 1: one-cycle pulse when `blk_out` updates.
- `blk_err` out 1: one-cycle pulse on watchdog abort.
- `des_data_in` out 64: input block to the core.
- `des_ready` out 1: start/hold request to the core.
- `des_ed_sel` out 1: 1 = encrypt pass, 0 = decrypt pass.
- `des_key_sel` out 2: 0 = K1, 1 = K2, 2 = K3.
- `des_next_data` in 1: core done strobe; `des_data_out` is valid in the same cycle.
- `des_data_out` in 64: core result.

## Operation
- States: IDLE, LOAD, RUN, DONE.
- IDLE:
  - With `blk_valid`=1: latch `blk_in` into the working register, latch `blk_mode`, set pass=0, go to LOAD.
  - Otherwise stay in IDLE.
- LOAD (exactly 1 cycle):
  - `des_ready`=0; `des_data_in`=working register.
  - `des_ed_sel` and `des_key_sel` are set for the current pass.
  - Go to RUN; clear the watchdog.
- Pass schedule:
  - Encrypt: (ed_sel, key) = (1,K1), (0,K2), (1,K3).
  - Decrypt: (ed_sel, key) = (0,K3), (1,K2), (0,K1).
- RUN:
  - `des_ready`=1. `des_data_in`, `des_ed_sel` and `des_key_sel` hold steady.
  - On `des_next_data`=1 with pass<2: working register ← `des_data_out`; pass+1; go to LOAD.
  - On `des_next_data`=1 with pass=2: `blk_out` ← `des_data_out`; go to DONE.
  - When the watchdog reaches TIMEOUT-1 without `des_next_data`: go to IDLE and pulse `blk_err` on that transition.
- DONE (1 cycle): `blk_out_valid`=1, `des_ready`=0; go to IDLE.
- Boundary rules:
  - `des_next_data` in IDLE, LOAD or DONE: ignored.
  - `blk_valid` while busy: ignored, not queued.
  - `des_next_data` in the same cycle as the timeout: `des_next_data` wins.
  - Pass counter is 2 bits; values 0..2 only. The value 3 is unreachable; if reached, return to IDLE.
  - Watchdog is `$clog2(TIMEOUT)` bits, saturates, and is cleared on every LOAD.
  - A new block may be accepted in the cycle after DONE or after abort.

## Timing
- Reset (n_rst=0 at a rising edge): every output is 0, state is IDLE, working register is 0.
- Reset mid-operation aborts immediately. No `blk_out_valid` or `blk_err` pulse is produced.
- Cycle numbering (each is a rising edge):
  - Edge 0: `blk_valid` sampled.
  - Cycle 1: LOAD.
  - Cycle 2 onward: RUN.
- With a core that asserts `des_next_data` on its L-th RUN cycle:
  - Each pass takes 1+L cycles.
  - `blk_out_valid` is high in cycle 3(1+L)+1.
  - `blk_busy` falls in the following cycle.
- `des_ready` is low for exactly one cycle between passes. This is the core's restart condition.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Structure
- `tdes_pkg`:
  - State enum `tdes_state_t`.
  - Key constants `KEY1`=2'd0, `KEY2`=2'd1, `KEY3`=2'd2.
  - `ED_ENC`=1'b1, `ED_DEC`=1'b0.
  - Schedule function mapping (mode, pass) → {ed_sel, key_sel}.
- One sub-module, `tdes_watchdog`: clear/enable counter that asserts `expired` at TIMEOUT-1. Synchronous active-low reset.

## Test plan
- Bench setup: behavioural DES model with L=16, XOR-with-key stand-in, K1/K2/K3 distinct.
- Encrypt:
  - Stimulus: `blk_in`=64'h2e0618e5790a7b59, `blk_mode`=1.
  - Required: key_sel sequence 0,1,2; ed_sel sequence 1,0,1; each pass's `des_data_in` equals the previous pass's `des_data_out`; `blk_out_valid` pulses at cycle 52; `blk_out` matches the model.
- Decrypt round trip:
  - Stimulus: feed the encrypt result back with `blk_mode`=0.
  - Required: key_sel sequence 2,1,0; ed_sel sequence 0,1,0; `blk_out`=64'h2e0618e5790a7b59.
- Handshake:
  - Required: `des_ready` is low for exactly 1 cycle before each pass and at DONE.
  - Stimulus: `blk_valid` held high during busy, and a spurious `des_next_data` in LOAD.
  - Required: neither has any effect; exactly one `blk_out_valid`.
- Timeout:
  - Stimulus: model never responds, TIMEOUT=32.
  - Required: `blk_err` pulses after 32 RUN cycles, then IDLE, `blk_busy`=0, no `blk_out_valid`. Repeat with `des_next_data` on the expiry cycle: the pass completes and there is no error.
- Reset:
  - Stimulus: `n_rst`=0 for 1 edge during pass 2.
  - Required: all outputs 0 on the next edge; a following encrypt of the same block produces the same result as the Encrypt scenario.
